bp_fe_queue_ckpt: RTL

//  Front-end end of the FE-queue interface: buffers fetch packets produced by the FE PC generator
//  and presents them to the back-end checker with checkpoint/replay semantics.
//  BE consumes speculatively (yumi), commits (deq), replays from the last commit (roll) or flushes (clr).

---
 rtl/bp_fe_queue_ckpt_pkg.sv | 8 +
 rtl/bp_fe_queue_ckpt_mem.sv | 25 ++
 rtl/bp_fe_queue_ckpt.sv | 99 +++++++++
 3 files changed

// File: rtl/bp_fe_queue_ckpt_pkg.sv
// bp_fe_queue_ckpt_pkg: default geometry for the FE-queue checkpoint buffer.
// The packet width stands in for the fe_queue_width_lp that the processor config would supply.
package bp_fe_queue_ckpt_pkg;

  localparam int fe_queue_width_gp = 64;
  localparam int fe_queue_els_gp   = 8;

endpackage

// File: rtl/bp_fe_queue_ckpt_mem.sv
// bp_fe_queue_ckpt_mem: els_p x width_p storage, one synchronous write port, one asynchronous read port.
// Storage is deliberately not reset; every read is qualified by pointer state in the parent.
module bp_fe_queue_ckpt_mem #(
  parameter int els_p   = 8,
  parameter int width_p = 64,
  localparam int addr_w = $clog2(els_p)
) (
  input  logic               clk_i,
  input  logic               w_v_i,
  input  logic [addr_w-1:0]  w_addr_i,
  input  logic [width_p-1:0] w_data_i,
  input  logic [addr_w-1:0]  r_addr_i,
  output logic [width_p-1:0] r_data_o
);

  logic [width_p-1:0] mem [els_p];

  // write the enqueued packet into its slot
  always_ff @(posedge clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_fe_queue_ckpt.sv
// bp_fe_queue_ckpt: FE-queue buffer with speculative read (rptr), commit (cptr) and enqueue (wptr)
// pointers. The back end consumes with yumi, commits with deq, replays from the commit point with
// roll and flushes with clr. Slots are only reused after commit, so a replay re-presents identical
// packets.
// Build option: BP_FE_QUEUE_BYPASS_EN forwards fe_queue_i straight to fe_queue_o when the queue has
// no unread entry and an enqueue fires (zero-latency); without it the latency is one cycle.
module bp_fe_queue_ckpt
  import bp_fe_queue_ckpt_pkg::*;
#(
  parameter int els_p   = fe_queue_els_gp,
  parameter int width_p = fe_queue_width_gp
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] fe_queue_i,
  input  logic               fe_queue_v_i,
  output logic               fe_queue_ready_o,
  output logic [width_p-1:0] fe_queue_o,
  output logic               fe_queue_v_o,
  input  logic               fe_queue_yumi_i,
  input  logic               fe_queue_deq_i,
  input  logic               fe_queue_roll_i,
  input  logic               fe_queue_clr_i
);

  // One extra wrap bit per pointer separates full from empty.
  localparam int ptr_w  = $clog2(els_p) + 1;
  localparam int addr_w = ptr_w - 1;

  logic [ptr_w-1:0]   wptr, rptr, cptr;
  logic [ptr_w-1:0]   cptr_next, occupancy;
  logic               live, full, enq, wr, unread;
  logic [width_p-1:0] rd_data;

  assign occupancy        = wptr - cptr;
  assign full             = (occupancy == ptr_w'(els_p));
  assign fe_queue_ready_o = live & ~full;
  assign enq              = fe_queue_v_i & fe_queue_ready_o;
  assign wr               = enq & ~fe_queue_clr_i;
  assign unread           = (rptr != wptr);
  assign cptr_next        = cptr + ptr_w'(fe_queue_deq_i);

  // ready stays low until the first clock after reset is released
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) live <= 1'b0;
    else            live <= 1'b1;
  end

  // pointer update: clr empties the queue at wptr; roll beats yumi for rptr
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else if (fe_queue_clr_i) begin
      rptr <= wptr;
      cptr <= wptr;
    end else begin
      if (enq) wptr <= wptr + ptr_w'(1);
      cptr <= cptr_next;
      if (fe_queue_roll_i)      rptr <= cptr_next;
      else if (fe_queue_yumi_i) rptr <= rptr + ptr_w'(1);
    end
  end

  bp_fe_queue_ckpt_mem #(
    .els_p   (els_p),
    .width_p (width_p)
  ) mem (
    .clk_i    (clk_i),
    .w_v_i    (wr),
    .w_addr_i (wptr[addr_w-1:0]),
    .w_data_i (fe_queue_i),
    .r_addr_i (rptr[addr_w-1:0]),
    .r_data_o (rd_data)
  );

  // output packet at rptr, forced to zero when nothing is unread
  always_comb begin
    fe_queue_v_o = unread;
    fe_queue_o   = unread ? rd_data : '0;
`ifdef BP_FE_QUEUE_BYPASS_EN
    if (wr && !unread) begin
      fe_queue_v_o = 1'b1;
      fe_queue_o   = fe_queue_i;
    end
`endif
  end

`ifndef SYNTHESIS
  a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fe_queue_yumi_i |-> fe_queue_v_o);
  a_deq_consumed: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (fe_queue_deq_i && !fe_queue_clr_i) |-> (cptr != rptr));
  a_no_overwrite: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    wr |-> !full);
`endif

endmodule
